// File: rtl/l3l4cs_cs_arbiter.sv
// l3l4cs_cs_arbiter: round-robin arbiter sharing one L3/L4 checksum engine
// between NUM_REQ packet requesters. The granted requester's beat stream is
// passed through to the engine. The engine result, or a forced timeout
// response if the engine stays silent, goes back to that requester as a
// one-cycle strobe.
module l3l4cs_cs_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WD = 64,
    parameter int TIMEOUT = 255,
    parameter int ID_WD   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_valid,
    output logic [DATA_WD-1:0]         eng_data,
    output logic                       eng_sop,
    output logic                       eng_last,
    input  logic                       eng_ready,
    input  logic                       eng_checksum_valid,
    input  logic [1:0]                 eng_l3_checksum,
    input  logic [1:0]                 eng_l4_checksum,
    input  logic                       eng_l2_error,
    input  logic                       eng_length_error,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [1:0]                 rsp_l3_checksum,
    output logic [1:0]                 rsp_l4_checksum,
    output logic                       rsp_l2_error,
    output logic                       rsp_length_error,
    output logic                       rsp_timeout,
    output logic                       busy,
    output logic [ID_WD-1:0]           grant_id
);

    localparam int CNT_WD = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_RES,
        S_RESP
    } state_t;

    state_t                           state;
    logic [ID_WD-1:0]                 rr_ptr;
    logic [CNT_WD-1:0]                tmo_cnt;
    logic                             sop_pending;
    logic [1:0]                       res_l3;
    logic [1:0]                       res_l4;
    logic                             res_l2;
    logic                             res_len;
    logic                             res_tmo;
    logic [NUM_REQ-1:0][DATA_WD-1:0]  req_data_arr;
    logic                             in_resp;

    assign req_data_arr = req_data;
    assign in_resp      = (state == S_RESP);

    // First requester with valid set, scanning upward from ptr with wrap.
    // The scan runs from the farthest offset down so the nearest one wins.
    function automatic logic [ID_WD-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_WD-1:0]   ptr);
        logic [ID_WD-1:0] pick;
        logic [ID_WD-1:0] idx;
        logic [ID_WD:0]   sum;
        pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (ID_WD + 1)'(i);
            if (sum >= (ID_WD + 1)'(NUM_REQ)) begin
                sum = sum - (ID_WD + 1)'(NUM_REQ);
            end
            idx = sum[ID_WD-1:0];
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Arbitration FSM: grant, stream, wait for the result or time out, respond.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // updates from pre-edge values regardless of statement order.
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            tmo_cnt     <= '0;
            sop_pending <= 1'b0;
            res_l3      <= '0;
            res_l4      <= '0;
            res_l2      <= 1'b0;
            res_len     <= 1'b0;
            res_tmo     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_id    <= rr_pick(req_valid, rr_ptr);
                        sop_pending <= 1'b1;
                        state       <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (eng_valid && eng_ready) begin
                        sop_pending <= 1'b0;
                        if (eng_last) begin
                            tmo_cnt <= '0;
                            state   <= S_WAIT_RES;
                        end
                    end
                end
                S_WAIT_RES: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (eng_checksum_valid) begin
                        res_l3  <= eng_l3_checksum;
                        res_l4  <= eng_l4_checksum;
                        res_l2  <= eng_l2_error;
                        res_len <= eng_length_error;
                        res_tmo <= 1'b0;
                        state   <= S_RESP;
                    end else if (tmo_cnt == CNT_WD'(TIMEOUT - 1)) begin
                        // Counter would reach TIMEOUT at this edge.
                        res_l3  <= '0;
                        res_l4  <= '0;
                        res_l2  <= 1'b0;
                        res_len <= 1'b0;
                        res_tmo <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (grant_id == ID_WD'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pass the granted requester's beat stream through to the engine.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        req_ready = '0;
        eng_valid = 1'b0;
        eng_data  = '0;
        eng_last  = 1'b0;
        eng_sop   = 1'b0;
        if (state == S_STREAM) begin
            req_ready[grant_id] = eng_ready;
            eng_valid           = req_valid[grant_id];
            eng_data            = req_data_arr[grant_id];
            eng_last            = req_last[grant_id];
            eng_sop             = sop_pending;
        end
    end

    assign rsp_valid        = in_resp ? (NUM_REQ'(1) << grant_id) : '0;
    assign rsp_l3_checksum  = in_resp ? res_l3 : 2'b00;
    assign rsp_l4_checksum  = in_resp ? res_l4 : 2'b00;
    assign rsp_l2_error     = in_resp & res_l2;
    assign rsp_length_error = in_resp & res_len;
    assign rsp_timeout      = in_resp & res_tmo;
    assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_l3l4cs_cs_arbiter.sv
// Scoreboard bench for l3l4cs_cs_arbiter. Packets are loaded per requester;
// a round-robin reference model orders them and predicts the engine beat
// stream and the responses, including result/timeout outcome and latency.
module tb_l3l4cs_cs_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int T  = 10;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              eng_valid;
    logic [DW-1:0]     eng_data;
    logic              eng_sop;
    logic              eng_last;
    logic              eng_ready;
    logic              eng_checksum_valid;
    logic [1:0]        eng_l3_checksum;
    logic [1:0]        eng_l4_checksum;
    logic              eng_l2_error;
    logic              eng_length_error;
    logic [N-1:0]      rsp_valid;
    logic [1:0]        rsp_l3_checksum;
    logic [1:0]        rsp_l4_checksum;
    logic              rsp_l2_error;
    logic              rsp_length_error;
    logic              rsp_timeout;
    logic              busy;
    logic [IW-1:0]     grant_id;

    l3l4cs_cs_arbiter #(.NUM_REQ(N), .DATA_WD(DW), .TIMEOUT(T)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_last           (req_last),
        .req_ready          (req_ready),
        .eng_valid          (eng_valid),
        .eng_data           (eng_data),
        .eng_sop            (eng_sop),
        .eng_last           (eng_last),
        .eng_ready          (eng_ready),
        .eng_checksum_valid (eng_checksum_valid),
        .eng_l3_checksum    (eng_l3_checksum),
        .eng_l4_checksum    (eng_l4_checksum),
        .eng_l2_error       (eng_l2_error),
        .eng_length_error   (eng_length_error),
        .rsp_valid          (rsp_valid),
        .rsp_l3_checksum    (rsp_l3_checksum),
        .rsp_l4_checksum    (rsp_l4_checksum),
        .rsp_l2_error       (rsp_l2_error),
        .rsp_length_error   (rsp_length_error),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy),
        .grant_id           (grant_id)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rbeat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          last;
        int            req;
    } ebeat_t;

    // delay: cycles after WAIT_RES entry before the engine strobes (-2 = never)
    typedef struct {
        int       req;
        int       delay;
        logic     tmo;
        logic [1:0] l3;
        logic [1:0] l4;
        logic     l2;
        logic     len;
    } res_t;

    rbeat_t req_q[N][$];
    ebeat_t exp_beats[$];
    res_t   exp_rsp[$];
    res_t   eng_plan[$];
    int     pk_req[$];
    int     pk_nb[$];

    int     m_rr_ptr;
    int     ready_mode;   // 0 always ready, 1 toggle, 2 random
    int     errors;
    int     checks;
    int     cyc;
    int     due;
    bit     due_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int nb);
        pk_req.push_back(r);
        pk_nb.push_back(nb);
    endtask

    // Reference model: serve loaded packets in round-robin order from the
    // model pointer, predicting beats, engine behaviour and responses.
    task automatic load(input int delay, input bit fix, input logic [5:0] f);
        int done[$];
        int left;
        int ptr;
        int g;
        int pi;
        foreach (pk_req[p]) done.push_back(0);
        left = pk_req.size();
        ptr  = m_rr_ptr;
        while (left > 0) begin
            g  = -1;
            pi = -1;
            for (int k = 0; k < N && g < 0; k++) begin
                int c;
                c = (ptr + k) % N;
                for (int p = 0; p < pk_req.size(); p++) begin
                    if (done[p] == 0 && pk_req[p] == c) begin
                        g  = c;
                        pi = p;
                        break;
                    end
                end
            end
            done[pi] = 1;
            left--;
            ptr = (g + 1) % N;
            for (int b = 0; b < pk_nb[pi]; b++) begin
                rbeat_t rb;
                ebeat_t eb;
                rb.data = $urandom;
                rb.last = (b == pk_nb[pi] - 1);
                req_q[g].push_back(rb);
                eb.data = rb.data;
                eb.sop  = (b == 0);
                eb.last = rb.last;
                eb.req  = g;
                exp_beats.push_back(eb);
            end
            begin
                res_t r;
                res_t e;
                int   d;
                if (delay == -1) begin
                    case ($urandom_range(0, 9))
                        0:       d = -2;
                        1:       d = T - 1;
                        2:       d = T;
                        3:       d = T + 1;
                        default: d = $urandom_range(0, T - 2);
                    endcase
                end else begin
                    d = delay;
                end
                r.req   = g;
                r.delay = d;
                r.tmo   = 1'b0;
                r.l3    = fix ? f[5:4] : 2'($urandom);
                r.l4    = fix ? f[3:2] : 2'($urandom);
                r.l2    = fix ? f[1]   : 1'($urandom);
                r.len   = fix ? f[0]   : 1'($urandom);
                e       = r;
                e.tmo   = !(d >= 0 && d <= T - 1);
                if (e.tmo) begin
                    e.l3  = 2'b00;
                    e.l4  = 2'b00;
                    e.l2  = 1'b0;
                    e.len = 1'b0;
                end
                eng_plan.push_back(r);
                exp_rsp.push_back(e);
            end
        end
        m_rr_ptr = ptr;
        pk_req.delete();
        pk_nb.delete();
    endtask

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_beats.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_outstanding"}, 64'(exp_rsp.size() + exp_beats.size()), 64'd0);
        if (exp_rsp.size() != 0 || exp_beats.size() != 0) summary_and_finish();
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Requesters: present the head beat of each queue, pop on handshake.
    initial begin
        logic [N-1:0] hs;
        logic         rst_s;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs    = req_valid & req_ready;
            rst_s = reset;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_s && hs[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
                if (req_q[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_data[i*DW +: DW]    = req_q[i][0].data;
                    req_last[i]             = req_q[i][0].last;
                end else begin
                    req_valid[i]            = 1'b0;
                    req_last[i]             = 1'b0;
                end
            end
        end
    end

    // Engine ready pattern.
    initial begin
        eng_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       eng_ready = !eng_ready;
                2:       eng_ready = 1'($urandom_range(0, 1));
                default: eng_ready = 1'b1;
            endcase
        end
    end

    // Engine result responder: follows the plan for each completed packet.
    initial begin
        res_t p;
        eng_checksum_valid = 1'b0;
        eng_l3_checksum    = '0;
        eng_l4_checksum    = '0;
        eng_l2_error       = 1'b0;
        eng_length_error   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && eng_valid && eng_ready && eng_last && eng_plan.size() > 0) begin
                p = eng_plan.pop_front();
                @(posedge clk);
                if (p.delay >= 0) begin
                    repeat (p.delay) @(posedge clk);
                    #1;
                    eng_checksum_valid = 1'b1;
                    eng_l3_checksum    = p.l3;
                    eng_l4_checksum    = p.l4;
                    eng_l2_error       = p.l2;
                    eng_length_error   = p.len;
                    @(posedge clk);
                    #1;
                    eng_checksum_valid = 1'b0;
                    eng_l3_checksum    = 2'($urandom);
                    eng_l4_checksum    = 2'($urandom);
                    eng_l2_error       = 1'($urandom);
                    eng_length_error   = 1'($urandom);
                end
            end
        end
    end

    // Monitor: compares beats, req_ready and responses against the scoreboard.
    initial begin
        logic [N-1:0] own;
        ebeat_t       eb;
        res_t         e;
        cyc       = 0;
        due       = 0;
        due_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                due_valid = 1'b0;
            end else begin
                own = '0;
                if (exp_beats.size() > 0) own[exp_beats[0].req] = 1'b1;
                if (eng_valid) check("req_ready", 64'(req_ready), 64'(eng_ready ? own : '0));
                else           check("req_ready_idle", 64'(req_ready & ~own), 64'd0);

                if (eng_valid && eng_ready) begin
                    check("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                    if (exp_beats.size() > 0) begin
                        eb = exp_beats.pop_front();
                        check("beat", {eng_data, eng_sop, eng_last, grant_id},
                              {eb.data, eb.sop, eb.last, IW'(eb.req)});
                        check("busy_stream", 64'(busy), 64'd1);
                        if (eb.last && exp_rsp.size() > 0) begin
                            due       = cyc + 1 + (exp_rsp[0].tmo ? T : exp_rsp[0].delay + 1);
                            due_valid = 1'b1;
                        end
                    end
                end

                if (rsp_valid != '0) begin
                    check("rsp_expected", 64'(exp_rsp.size() > 0), 64'd1);
                    if (exp_rsp.size() > 0) begin
                        logic [N-1:0] oh;
                        e  = exp_rsp.pop_front();
                        oh = '0;
                        oh[e.req] = 1'b1;
                        check("rsp", {rsp_valid, rsp_l3_checksum, rsp_l4_checksum,
                                      rsp_l2_error, rsp_length_error, rsp_timeout},
                              {oh, e.l3, e.l4, e.l2, e.len, e.tmo});
                        check("rsp_armed", 64'(due_valid), 64'd1);
                        check("rsp_latency", 64'(cyc), 64'(due));
                        check("busy_resp", 64'(busy), 64'd1);
                        due_valid = 1'b0;
                    end
                end else begin
                    check("rsp_fields_idle", {rsp_l3_checksum, rsp_l4_checksum,
                                              rsp_l2_error, rsp_length_error, rsp_timeout}, 64'd0);
                end

                if (due_valid && cyc > due) begin
                    check("rsp_missing", 64'(cyc), 64'(due));
                    due_valid = 1'b0;
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "time limit");
    end

    // Directed and random scenarios.
    initial begin
        int n;
        errors     = 0;
        checks     = 0;
        m_rr_ptr   = 0;
        ready_mode = 0;
        reset      = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, eng_valid, eng_sop, eng_last, req_ready, rsp_valid,
                              rsp_l3_checksum, rsp_l4_checksum, rsp_l2_error,
                              rsp_length_error, rsp_timeout, grant_id}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Requester 0, 3 beats, result l3=01 l4=01 two cycles after the last beat.
        add_pkt(0, 3);
        load(1, 1'b1, 6'b01_01_0_0);
        wait_done("single");

        // Reset on beat 2 of a packet from requester 1.
        add_pkt(1, 4);
        load(-1, 1'b0, '0);
        n = 0;
        while (exp_beats.size() > 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reset_setup", 64'(exp_beats.size()), 64'd2);
        reset = 1'b1;
        exp_beats.delete();
        exp_rsp.delete();
        eng_plan.delete();
        for (int i = 0; i < N; i++) req_q[i].delete();
        m_rr_ptr = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", {busy, eng_valid, eng_sop, eng_last, req_ready, rsp_valid,
                                     rsp_l3_checksum, rsp_l4_checksum, rsp_l2_error,
                                     rsp_length_error, rsp_timeout, grant_id}, 64'd0);
        @(posedge clk);
        #2;
        add_pkt(1, 2);
        add_pkt(3, 2);
        load(-1, 1'b0, '0);
        wait_done("after_reset");

        // All requesters continuously valid, 1-beat packets: order 0,1,2,3,0.
        add_pkt(0, 1);
        add_pkt(0, 1);
        add_pkt(1, 1);
        add_pkt(2, 1);
        add_pkt(3, 1);
        load(-1, 1'b0, '0);
        wait_done("rr_order");

        // Toggling engine ready during a 4-beat packet from requester 2.
        ready_mode = 1;
        add_pkt(2, 4);
        load(-1, 1'b0, '0);
        wait_done("stall");
        ready_mode = 0;

        // Silent engine: timeout response, then a normal grant.
        add_pkt(3, 2);
        load(-2, 1'b0, '0);
        wait_done("timeout");
        add_pkt(0, 2);
        load(2, 1'b0, '0);
        wait_done("after_timeout");

        // Result in the same cycle the counter reaches TIMEOUT.
        add_pkt(1, 3);
        load(T - 1, 1'b1, 6'b10_11_1_0);
        wait_done("collision");

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            int mask;
            mask       = $urandom_range(1, 15);
            ready_mode = $urandom_range(0, 2);
            for (int r = 0; r < N; r++) begin
                if (((mask >> r) & 1) == 1) begin
                    add_pkt(r, $urandom_range(1, 5));
                    if ($urandom_range(0, 3) == 0) add_pkt(r, $urandom_range(1, 3));
                end
            end
            load(-1, 1'b0, '0);
            wait_done("random");
        end

        summary_and_finish();
    end

endmodule
